// File: rtl/mutative_fill_ctrl_if.sv
// Bus bundle between the mutative cache miss-handling engine and its environment
// (replacement policy, tag/data arrays, memory port, pipeline miss request).
interface mutative_fill_ctrl_if #(
  parameter int WAYS         = 8,
  parameter int WAY_IDX_BITS = 3,
  parameter int SET_BITS     = 4,
  parameter int OFFSET_BITS  = 5,
  parameter int TAG_BITS     = 23,
  parameter int LINE_BITS    = 256
);
  localparam int ADDR_BITS = TAG_BITS + SET_BITS + OFFSET_BITS;

  logic                    miss_req;
  logic [ADDR_BITS-1:0]    miss_addr;
  logic [1:0]              setup;
  logic [WAY_IDX_BITS-1:0] evict_way;
  logic [WAYS-1:0]         evict_we;
  logic                    victim_valid;
  logic                    victim_dirty;
  logic [TAG_BITS-1:0]     victim_tag;
  logic [LINE_BITS-1:0]    victim_data;
  logic                    mem_read;
  logic                    mem_write;
  logic [ADDR_BITS-1:0]    mem_addr;
  logic [LINE_BITS-1:0]    mem_wdata;
  logic [LINE_BITS-1:0]    mem_rdata;
  logic                    mem_resp;
  logic [WAYS-1:0]         arr_we;
  logic [SET_BITS-1:0]     arr_set;
  logic [TAG_BITS-1:0]     arr_wtag;
  logic [LINE_BITS-1:0]    arr_wdata;
  logic                    upd_valid;
  logic [WAY_IDX_BITS-1:0] upd_way;
  logic                    miss_done;

  // master = the fill controller, slave = pipeline/policy/arrays/memory side
  modport master (
    input  miss_req, miss_addr, setup, evict_way, evict_we,
           victim_valid, victim_dirty, victim_tag, victim_data,
           mem_rdata, mem_resp,
    output mem_read, mem_write, mem_addr, mem_wdata,
           arr_we, arr_set, arr_wtag, arr_wdata,
           upd_valid, upd_way, miss_done
  );

  modport slave (
    output miss_req, miss_addr, setup, evict_way, evict_we,
           victim_valid, victim_dirty, victim_tag, victim_data,
           mem_rdata, mem_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata,
           arr_we, arr_set, arr_wtag, arr_wdata,
           upd_valid, upd_way, miss_done
  );
endinterface

// File: rtl/mutative_fill_ctrl.sv
// Miss-handling engine: captures the policy's victim, writes it back if dirty,
// fetches the missing line, installs it and reports the virtual way to the PLRU.
module mutative_fill_ctrl #(
  parameter int WAYS         = 8,
  parameter int WAY_IDX_BITS = 3,
  parameter int SET_BITS     = 4,
  parameter int OFFSET_BITS  = 5,
  parameter int TAG_BITS     = 23,
  parameter int LINE_BITS    = 256
) (
  input logic                clk,
  input logic                rst_n,
  mutative_fill_ctrl_if.master bus
);
  localparam int ADDR_BITS = TAG_BITS + SET_BITS + OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE, CAPTURE, WRITEBACK, FILL, INSTALL, DONE
  } state_t;

  state_t                  state, next_state;
  logic [TAG_BITS-1:0]     tag_q;
  logic [SET_BITS-1:0]     set_q;
  logic [1:0]              setup_q;
  logic [WAY_IDX_BITS-1:0] evict_way_q;
  logic [WAYS-1:0]         evict_we_q;
  logic [TAG_BITS-1:0]     victim_tag_q;
  logic [LINE_BITS-1:0]    victim_data_q;
  logic [LINE_BITS-1:0]    fill_data_q;
  logic [WAY_IDX_BITS-1:0] virt_way;
  logic                    unused_offset;

  // The byte offset never matters: every memory transaction is line-aligned.
  assign unused_offset = ^bus.miss_addr[OFFSET_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Everything about a miss is frozen at IDLE/CAPTURE so later input churn is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q         <= '0;
      set_q         <= '0;
      setup_q       <= '0;
      evict_way_q   <= '0;
      evict_we_q    <= '0;
      victim_tag_q  <= '0;
      victim_data_q <= '0;
      fill_data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_req) begin
            tag_q   <= bus.miss_addr[ADDR_BITS-1 -: TAG_BITS];
            set_q   <= bus.miss_addr[OFFSET_BITS +: SET_BITS];
            setup_q <= bus.setup;
          end
        end
        CAPTURE: begin
          evict_way_q   <= bus.evict_way;
          evict_we_q    <= bus.evict_we;
          victim_tag_q  <= bus.victim_tag;
          victim_data_q <= bus.victim_data;
        end
        FILL: begin
          if (bus.mem_resp) fill_data_q <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Physical victim way folded down to the way index space of the active associativity.
  always_comb begin
    virt_way = '0;
    case (setup_q)
      2'b01:   virt_way = evict_way_q & WAY_IDX_BITS'(1);
      2'b10:   virt_way = evict_way_q & WAY_IDX_BITS'(3);
      2'b11:   virt_way = evict_way_q;
      default: virt_way = '0;
    endcase
  end

  assign bus.upd_way = virt_way;

  always_comb begin
    next_state    = state;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.arr_we    = '0;
    bus.arr_set   = '0;
    bus.arr_wtag  = '0;
    bus.arr_wdata = '0;
    bus.upd_valid = 1'b0;
    bus.miss_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.miss_req) next_state = CAPTURE;
      end
      CAPTURE: begin
        bus.arr_set = set_q;
        next_state  = (bus.victim_valid && bus.victim_dirty) ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {victim_tag_q, set_q, OFFSET_BITS'(0)};
        bus.mem_wdata = victim_data_q;
        if (bus.mem_resp) next_state = FILL;
      end
      FILL: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {tag_q, set_q, OFFSET_BITS'(0)};
        if (bus.mem_resp) next_state = INSTALL;
      end
      INSTALL: begin
        bus.arr_we    = evict_we_q;
        bus.arr_set   = set_q;
        bus.arr_wtag  = tag_q;
        bus.arr_wdata = fill_data_q;
        bus.upd_valid = (setup_q != 2'b00);
        next_state    = DONE;
      end
      DONE: begin
        bus.miss_done = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end
endmodule
